// File: rtl/ram_bytelane_rmw_if.sv
// +--------------------------------------------------------------------+
// | ram_bytelane_rmw_if : external word port and byte port bundle       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface ram_bytelane_rmw_if #(
   parameter int WORD_W = 64,
   parameter int DEPTH  = 128
);
   localparam int LANES = WORD_W / 8;
   localparam int WA    = $clog2(DEPTH);
   localparam int BA    = WA + $clog2(LANES);

   logic              mode;
   logic              ext_valid;
   logic              ext_ready;
   logic              ext_we;
   logic [WA-1:0]     ext_addr;
   logic [WORD_W-1:0] ext_wdata;
   logic              ext_rvalid;
   logic [WORD_W-1:0] ext_rdata;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_size;
   logic [BA-1:0]     req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [WORD_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output mode, ext_valid, ext_we, ext_addr, ext_wdata,
      input  ext_ready, ext_rvalid, ext_rdata,
      output req_valid, req_we, req_size, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  mode, ext_valid, ext_we, ext_addr, ext_wdata,
      output ext_ready, ext_rvalid, ext_rdata,
      input  req_valid, req_we, req_size, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

`default_nettype wire

// File: rtl/ram_bytelane_rmw.sv
// +--------------------------------------------------------------------+
// | ram_bytelane_rmw : single-port scratch RAM, big-endian byte port    |
// | with read-modify-write sub-word stores, plus a word bulk port.      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ram_bytelane_rmw #(
   parameter int WORD_W = 64,
   parameter int DEPTH  = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   ram_bytelane_rmw_if.slave   bus
);
   localparam int LANES = WORD_W / 8;
   localparam int LW    = $clog2(LANES);
   localparam int WA    = $clog2(DEPTH);
   localparam int BA    = WA + LW;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MERGE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rd_word;
   logic [WA-1:0]     r_waddr;
   logic [LW-1:0]     r_lane;
   logic [2:0]        r_size;
   logic [WORD_W-1:0] r_wdata;
   logic              r_resp_ext;
   logic              r_resp_rd;
   logic              r_err;

   logic              w_mem_we;
   logic              w_mem_re;
   logic [WA-1:0]     w_mem_addr;
   logic [WORD_W-1:0] w_mem_wdata;
   logic              w_accept;

   logic [WA-1:0]     w_req_word;
   logic [LW-1:0]     w_req_lane;
   logic [LW-1:0]     w_align;
   logic              w_req_err;
   logic              w_req_full;

   int                w_shift;
   logic [WORD_W-1:0] w_size_mask;
   logic [WORD_W-1:0] w_merged;
   logic [WORD_W-1:0] w_extract;
   logic              w_in_resp;

   // Bit distance from word LSB to the LSB of the last covered lane (big-endian lanes).
   function automatic int f_shift(input logic [LW-1:0] lane, input logic [2:0] size);
      return WORD_W - 8 * (int'(lane) + (1 << size));
   endfunction

   function automatic logic [WORD_W-1:0] f_mask(input logic [2:0] size);
      logic [WORD_W-1:0] ones;
      ones = '1;
      return ~(ones << (8 << size));
   endfunction

   assign w_req_word = bus.req_addr[BA-1:LW];
   assign w_req_lane = bus.req_addr[LW-1:0];
   assign w_align    = (LW'(1) << bus.req_size) - LW'(1);
   assign w_req_err  = (bus.req_size > 3'(LW)) || ((w_req_lane & w_align) != '0);
   assign w_req_full = (bus.req_size == 3'(LW));

   assign w_shift     = f_shift(r_lane, r_size);
   assign w_size_mask = f_mask(r_size);
   assign w_merged    = (r_rd_word & ~(w_size_mask << w_shift))
                      | ((r_wdata & w_size_mask) << w_shift);
   assign w_extract   = (r_rd_word >> w_shift) & w_size_mask;

   assign w_accept = (r_state == S_IDLE) && (bus.mode ? bus.ext_valid : bus.req_valid);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next         = r_state;
      w_mem_we       = 1'b0;
      w_mem_re       = 1'b0;
      w_mem_addr     = '0;
      w_mem_wdata    = '0;
      bus.ext_ready  = 1'b0;
      bus.req_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.ext_ready = bus.mode;
            bus.req_ready = !bus.mode;
            if (bus.mode && bus.ext_valid) begin
               w_mem_addr = bus.ext_addr;
               if (bus.ext_we) begin
                  w_mem_we    = 1'b1;
                  w_mem_wdata = bus.ext_wdata;
               end else begin
                  w_mem_re = 1'b1;
                  w_next   = S_RESP;
               end
            end else if (!bus.mode && bus.req_valid) begin
               w_mem_addr = w_req_word;
               w_next     = S_RESP;
               if (w_req_err) begin
                  w_next = S_RESP;
               end else if (!bus.req_we) begin
                  w_mem_re = 1'b1;
               end else if (w_req_full) begin
                  w_mem_we    = 1'b1;
                  w_mem_wdata = bus.req_wdata;
               end else begin
                  w_mem_re = 1'b1;
                  w_next   = S_MERGE;
               end
            end
         end
         S_MERGE: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_waddr;
            w_mem_wdata = w_merged;
            w_next      = S_RESP;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Array writes are suppressed under reset so an interrupted merge leaves the word intact.
   always_ff @(posedge clk) begin
      if (rst_n && w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
      if (w_mem_re) begin
         r_rd_word <= r_mem[w_mem_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_resp_ext <= bus.mode;
         r_resp_rd  <= bus.mode ? !bus.ext_we : !bus.req_we;
         r_err      <= !bus.mode && w_req_err;
         r_waddr    <= w_req_word;
         r_lane     <= w_req_lane;
         r_size     <= bus.req_size;
         r_wdata    <= bus.req_wdata;
      end
   end

   assign w_in_resp      = (r_state == S_RESP);
   assign bus.ext_rvalid = w_in_resp && r_resp_ext && r_resp_rd;
   assign bus.ext_rdata  = bus.ext_rvalid ? r_rd_word : '0;
   assign bus.rsp_valid  = w_in_resp && !r_resp_ext;
   assign bus.rsp_err    = bus.rsp_valid && r_err;
   assign bus.rsp_rdata  = (bus.rsp_valid && !r_err && r_resp_rd) ? w_extract : '0;

endmodule

`default_nettype wire
